// File: rtl/fpu_pkg.sv
// Shared binary32 definitions for the FPU datapath: field widths, special
// encodings, operand classes and the divider FSM states.
package fpu_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int DIV_STEPS = 26;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_t;

  typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, ROUND, DONE} div_state_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational binary32 unpack/classify; exponent-0 inputs are flushed to zero.
module fp32_classify
  import fpu_pkg::*;
(
  input  logic [31:0] x,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [23:0] mant,
  output fp_class_t   cls
);

  fp32_t f_s;

  // Split fields and pick the operand class.
  always_comb begin
    f_s  = x;
    sign = f_s.sign;
    exp  = f_s.exp;
    mant = {1'b1, f_s.frac};
    if (f_s.exp == 8'd0) begin
      cls = ZERO;
    end else if (f_s.exp == 8'hFF) begin
      if (f_s.frac == 23'd0) begin
        cls = INF;
      end else begin
        cls = NAN;
      end
    end else begin
      cls = NORMAL;
    end
  end

endmodule

// File: rtl/fpu_div_sp.sv
// Iterative binary32 divider, radix-2 restoring, fixed 28-cycle start-to-finish.
// Optional FPU_DIV_FLAGS_EN adds flags[4:0] = {invalid, div_by_zero, overflow, underflow, zero}.
module fpu_div_sp
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] o,
  output logic        finish
`ifdef FPU_DIV_FLAGS_EN
  ,
  output logic [4:0]  flags
`endif
);

  div_state_t state_r, state_s;
  logic [31:0] a_r, b_r;
  logic        sign_r;
  logic signed [9:0] exp_r;
  fp_class_t   ca_r, cb_r;
  logic [24:0] rem_r;
  logic [25:0] q_r;
  logic [4:0]  cnt_r;

  logic        sa_s, sb_s;
  logic [7:0]  ea_s, eb_s;
  logic [23:0] ma_s, mb_s;
  fp_class_t   ca_s, cb_s;

  fp32_classify u_cls_a (.x(a_r), .sign(sa_s), .exp(ea_s), .mant(ma_s), .cls(ca_s));
  fp32_classify u_cls_b (.x(b_r), .sign(sb_s), .exp(eb_s), .mant(mb_s), .cls(cb_s));

  // The remainder stays below 2*mb, so the subtraction fits in 24 bits when taken.
  logic        ge_s;
  logic [23:0] diff_s;
  assign ge_s   = (rem_r >= {1'b0, mb_s});
  assign diff_s = rem_r[23:0] - mb_s;

  logic        guard_s, sticky_s, inc_s;
  logic [23:0] mant_pre_s, mant_s;
  logic [24:0] sum_s;
  logic signed [9:0] e_adj_s, e_fin_s;
  logic        nan_s, inf_s, zero_s, ovf_s, unf_s;
  logic [31:0] res_s;

  // Normalise, round to nearest even, then apply special-operand overrides.
  always_comb begin
    if (q_r[25]) begin
      mant_pre_s = q_r[25:2];
      guard_s    = q_r[1];
      sticky_s   = q_r[0] | (rem_r != 25'd0);
      e_adj_s    = exp_r;
    end else begin
      mant_pre_s = q_r[24:1];
      guard_s    = q_r[0];
      sticky_s   = (rem_r != 25'd0);
      e_adj_s    = exp_r - 10'sd1;
    end
    inc_s = guard_s & (sticky_s | mant_pre_s[0]);
    sum_s = {1'b0, mant_pre_s} + {24'd0, inc_s};
    if (sum_s[24]) begin
      mant_s  = sum_s[24:1];
      e_fin_s = e_adj_s + 10'sd1;
    end else begin
      mant_s  = sum_s[23:0];
      e_fin_s = e_adj_s;
    end
    ovf_s  = (e_fin_s >= 10'sd255);
    unf_s  = (e_fin_s <= 10'sd0);
    nan_s  = (ca_r == NAN) | (cb_r == NAN) | ((ca_r == ZERO) & (cb_r == ZERO)) |
             ((ca_r == INF) & (cb_r == INF));
    inf_s  = (ca_r == INF) | (cb_r == ZERO);
    zero_s = (ca_r == ZERO) | (cb_r == INF);
    if (nan_s) begin
      res_s = QNAN;
    end else if (inf_s) begin
      res_s = {sign_r, POS_INF[30:0]};
    end else if (zero_s) begin
      res_s = {sign_r, 31'd0};
    end else if (ovf_s) begin
      res_s = {sign_r, POS_INF[30:0]};
    end else if (unf_s) begin
      res_s = {sign_r, 31'd0};
    end else begin
      res_s = {sign_r, e_fin_s[7:0], mant_s[22:0]};
    end
  end

  // Next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = LOAD; else state_s = IDLE;
      LOAD:    state_s = DIVIDE;
      DIVIDE:  if (cnt_r == 5'(DIV_STEPS - 1)) state_s = ROUND; else state_s = DIVIDE;
      ROUND:   state_s = DONE;
      DONE:    if (start) state_s = LOAD; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // State register and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      sign_r  <= 1'b0;
      exp_r   <= 10'sd0;
      ca_r    <= ZERO;
      cb_r    <= ZERO;
      rem_r   <= 25'd0;
      q_r     <= 26'd0;
      cnt_r   <= 5'd0;
      o       <= 32'd0;
      finish  <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            finish <= 1'b0;
          end
        end
        LOAD: begin
          sign_r <= sa_s ^ sb_s;
          exp_r  <= $signed({2'b00, ea_s}) - $signed({2'b00, eb_s}) + 10'(EXP_BIAS);
          ca_r   <= ca_s;
          cb_r   <= cb_s;
          rem_r  <= {1'b0, ma_s};
          q_r    <= 26'd0;
          cnt_r  <= 5'd0;
        end
        DIVIDE: begin
          cnt_r <= cnt_r + 5'd1;
          if (ge_s) begin
            q_r   <= {q_r[24:0], 1'b1};
            rem_r <= {diff_s, 1'b0};
          end else begin
            q_r   <= {q_r[24:0], 1'b0};
            rem_r <= {rem_r[23:0], 1'b0};
          end
        end
        ROUND: begin
          o      <= res_s;
          finish <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FPU_DIV_FLAGS_EN
  logic [4:0] flags_s;

  // Exception flags, captured alongside o.
  always_comb begin
    flags_s[4] = nan_s;
    flags_s[3] = (ca_r == NORMAL) & (cb_r == ZERO);
    flags_s[2] = ~(nan_s | inf_s | zero_s) & ovf_s;
    flags_s[1] = ~(nan_s | inf_s | zero_s) & ~ovf_s & unf_s;
    flags_s[0] = (res_s[30:0] == 31'd0);
  end

  // Flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 5'd0;
    end else if (state_r == ROUND) begin
      flags <= flags_s;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_div_sp.sv
// Directed self-checking bench for fpu_div_sp: results, 28-cycle latency,
// output holding, ignored starts and asynchronous reset abort.
module tb_fpu_div_sp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] o;
  logic        finish;

  int checks = 0;
  int errors = 0;

  fpu_div_sp dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .o(o), .finish(finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Leaves the bench half a cycle after the edge that samples start.
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called half a cycle after the start edge N; skip = negedges already spent.
  task automatic wait_result(input string tag, input logic [31:0] expv, input int skip);
    repeat (27 - skip) @(negedge clk);
    chk({tag, "_finish_early"}, {31'd0, finish}, 32'd0);
    @(negedge clk);
    chk({tag, "_finish"}, {31'd0, finish}, 32'd1);
    chk({tag, "_o"}, o, expv);
  endtask

  task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] expv);
    start_op(av, bv);
    wait_result(tag, expv, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_o", o, 32'd0);
    chk("reset_finish", {31'd0, finish}, 32'd0);
    rst_n = 1'b1;

    run("div_6_2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
    repeat (5) @(negedge clk);
    chk("hold_finish", {31'd0, finish}, 32'd1);
    chk("hold_o", o, 32'h4040_0000);

    run("div_1_3", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB);
    run("div_neg", 32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000);
    run("one_by_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000);
    run("zero_by_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000);
    run("inf_by_inf", 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000);
    run("negzero_by_2", 32'h8000_0000, 32'h4000_0000, 32'h8000_0000);
    run("overflow", 32'h7F7F_FFFF, 32'h3E80_0000, 32'h7F80_0000);
    run("underflow", 32'h0080_0000, 32'h4B00_0000, 32'h0000_0000);

    // Second start 5 cycles into a divide must be ignored.
    start_op(32'h40C0_0000, 32'h4000_0000);
    repeat (4) @(negedge clk);
    chk("midop_o_prev", o, 32'h0000_0000);
    a = 32'h3F80_0000;
    b = 32'h4040_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_result("ignored_start", 32'h4040_0000, 5);

    // Start in DONE drops finish at once, o holds until the new ROUND.
    start_op(32'hC0F0_0000, 32'h4020_0000);
    chk("done_start_finish", {31'd0, finish}, 32'd0);
    chk("done_start_o_hold", o, 32'h4040_0000);
    wait_result("after_done_start", 32'hC040_0000, 0);

    // Asynchronous reset around cycle 10 aborts the divide.
    start_op(32'h3F80_0000, 32'h4040_0000);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_o", o, 32'd0);
    chk("abort_finish", {31'd0, finish}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_result", {31'd0, finish}, 32'd0);
    run("post_reset", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_div_sp.md
Name: fpu_div_sp

Overview:
- Iterative IEEE-754 binary32 divider computing o = a / b.
- Uses radix-2 restoring mantissa division with a fixed multi-cycle latency and a start/finish handshake.
- Sits beside the adder and multiplier inside the FPU datapath; the FPU wrapper selects its result and finish flag when funct = 2.

Parameters:
- None. The format is fixed to binary32: 1 sign, 8 exponent, 23 fraction bits.

Ports:
- clk     in   1   rising-edge clock
- rst_n   in   1   asynchronous active-low reset
- start   in   1   one-cycle request; a and b are sampled on the same edge
- a       in   32  dividend, binary32
- b       in   32  divisor, binary32
- o       out  32  quotient, binary32
- finish  out  1   result valid

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = IDLE, o = 0, finish = 0, all internal registers cleared.
  - Reset asserted mid-operation aborts the divide; no result is produced.
- FSM states: IDLE -> LOAD -> DIVIDE (26 cycles) -> ROUND -> DONE.
  - DONE holds until the next start; a start in DONE goes to LOAD.
  - start while in LOAD, DIVIDE or ROUND is ignored.
- Timing and output holding:
  - start sampled high at edge N gives finish = 1 after edge N+28. Latency is the same for special operands.
  - finish stays high and o stays stable throughout DONE.
  - finish drops on the edge that accepts a new start.
  - o keeps the previous result until ROUND of the new operation overwrites it.
- LOAD:
  - Unpack sign, exponent and fraction. Mantissa = {1, frac}, 24 bits.
  - Inputs with exponent 0 are treated as zero (flush-to-zero).
  - Classify each operand as zero, inf, NaN or normal.
  - Sign = a[31] ^ b[31].
  - Biased exponent e = ea - eb + 127, computed in 10-bit signed arithmetic.
- DIVIDE: each cycle produces one quotient bit Q[25..0] of ma/mb; Q[25] has weight 2^0. Remainder width is 25 bits.
- ROUND:
  - If Q[25] = 1: mant = Q[25:2], guard = Q[1], sticky = Q[0] | (rem != 0).
  - Else: mant = Q[24:1], guard = Q[0], sticky = (rem != 0), e = e - 1.
  - Rounding is round-to-nearest-even: increment when guard & (sticky | mant[0]).
  - If the increment carries out of the mantissa, shift right and e = e + 1.
  - e >= 255 gives signed infinity.
  - e <= 0 gives signed zero (no denormal output).
- Special-case priority (overrides the datapath result in ROUND):
  - Either operand NaN, 0/0, or inf/inf -> 0x7FC00000 (canonical NaN).
  - inf/x, or x/0 with x nonzero -> signed infinity.
  - 0/x, or x/inf -> signed zero.

Optional Feature:
- Macro FPU_DIV_FLAGS_EN.
- When defined, the block adds output port flags[4:0] = {invalid, div_by_zero, overflow, underflow, zero}.
  - flags is registered together with o and follows the same holding rules.
  - flags resets to 0.
  - zero = 1 when the result is ±0.
- When undefined, the port and its logic are absent; o and finish behave identically in both cases.

Decomposition:
- Package fpu_pkg holds:
  - constants EXP_BIAS = 127, EXP_W = 8, FRAC_W = 23, QNAN = 32'h7FC0_0000, POS_INF = 32'h7F80_0000;
  - typedef fp32_t (packed struct: sign, exp, frac);
  - enum fp_class_t {ZERO, NORMAL, INF, NAN};
  - the FSM state enum.
- One sub-module is natural: fp32_classify, a combinational unpack/classify block shared with the adder and multiplier.

Test Plan:
- start with a = 0x40C00000, b = 0x40000000 (6/2) -> finish high 28 cycles later, o = 0x40400000; finish and o held until the next start.
- a = 0x3F800000, b = 0x40400000 (1/3) -> o = 0x3EAAAAAB (round-up path); a = 0xC0F00000, b = 0x40200000 -> o = 0xC0400000.
- Specials:
  - 0x3F800000 / 0x00000000 -> 0x7F800000;
  - 0 / 0 -> 0x7FC00000;
  - 0x7F800000 / 0x7F800000 -> 0x7FC00000;
  - 0x80000000 / 0x40000000 -> 0x80000000.
  - Latency is still 28 cycles in every case.
- Range limits: 0x7F7FFFFF / 0x3E800000 -> 0x7F800000 (overflow); 0x00800000 / 0x4B000000 -> 0x00000000 (underflow).
- Handshake: second start pulsed 5 cycles into a divide is ignored and the first result is unchanged; start in DONE drops finish on the next edge.
- Reset: rst_n pulsed low at cycle 10 of a divide -> o = 0 and finish = 0 immediately; a new start afterwards completes normally.
